// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between instruction fetch and data access.
// Data wins by default; a bounded data burst lets a waiting fetch through.
module sram_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                sram_en,
  output logic [DATA_W/8-1:0] sram_wen,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_DATA_BURST);

  logic [3:0] burst_q, burst_d;
  logic [1:0] owner_q, owner_d;
  logic       owner_wr_q, owner_wr_d;
  logic       grant_data, grant_inst;

  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (!reset) begin
      if (data_req && !(inst_req && (burst_q == BURST_LIMIT))) begin
        grant_data = 1'b1;
      end else if (inst_req) begin
        grant_inst = 1'b1;
      end
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_data) begin
      sram_en   = 1'b1;
      sram_addr = data_addr;
      if (data_wr) begin
        sram_wen   = data_wstrb;
        sram_wdata = data_wdata;
      end
    end else if (grant_inst) begin
      sram_en   = 1'b1;
      sram_addr = inst_addr;
    end
  end

  always_comb begin
    burst_d = burst_q;
    if (!inst_req || grant_inst) begin
      burst_d = '0;
    end else if (grant_data && (burst_q < BURST_LIMIT)) begin
      burst_d = burst_q + 4'd1;
    end
    owner_d    = {grant_data, grant_inst};
    owner_wr_d = grant_data & data_wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q    <= '0;
      owner_q    <= '0;
      owner_wr_q <= 1'b0;
    end else begin
      burst_q    <= burst_d;
      owner_q    <= owner_d;
      owner_wr_q <= owner_wr_d;
    end
  end

  // Reset asserted the cycle after a grant drops that response outright.
  assign inst_data_ok = owner_q[0] & ~reset;
  assign data_data_ok = owner_q[1] & ~reset;
  assign inst_rdata   = inst_data_ok ? sram_rdata : '0;
  assign data_rdata   = (data_data_ok && !owner_wr_q) ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: behavioural SRAM, a request-level reference
// model checked every cycle, and literal expectations for the key scenarios.
module tb_sram_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          sram_en;
  logic [SW-1:0] sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural single-port SRAM, read data one cycle after enable.
  logic [DW-1:0] sram_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    logic [DW-1:0] word;
    if (sram_en) begin
      word = sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : '0;
      if (sram_wen != '0) begin
        for (int b = 0; b < SW; b++)
          if (sram_wen[b]) word[8*b +: 8] = sram_wdata[8*b +: 8];
        sram_mem[sram_addr] = word;
      end else begin
        sram_rdata <= word;
      end
    end
  end

  // Reference model state: memory as seen by requesters, outstanding response,
  // and how many data wins a waiting fetch has sat through.
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic          pend_i = 1'b0, pend_d = 1'b0;
  logic [DW-1:0] pend_irdata = '0, pend_drdata = '0;
  int            m_waits = 0;

  logic          s_iaok, s_daok, s_idok, s_ddok, s_en;
  logic [DW-1:0] s_irdata, s_drdata, s_wdata;
  logic [AW-1:0] s_addr;
  logic [SW-1:0] s_wen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic model_cycle();
    logic          gd, gi;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] word;
    gd = !reset && data_req && !(inst_req && (m_waits == MAXB));
    gi = !reset && !gd && inst_req;
    e_addr = gd ? data_addr : (gi ? inst_addr : '0);

    chk("inst_addr_ok", 64'(inst_addr_ok), 64'(gi));
    chk("data_addr_ok", 64'(data_addr_ok), 64'(gd));
    chk("sram_en", 64'(sram_en), 64'(gd | gi));
    chk("sram_addr", 64'(sram_addr), 64'(e_addr));
    chk("sram_wen", 64'(sram_wen), 64'((gd && data_wr) ? data_wstrb : '0));
    chk("sram_wdata", 64'(sram_wdata), 64'((gd && data_wr) ? data_wdata : '0));
    chk("inst_data_ok", 64'(inst_data_ok), 64'(pend_i & !reset));
    chk("data_data_ok", 64'(data_data_ok), 64'(pend_d & !reset));
    chk("inst_rdata", 64'(inst_rdata), 64'(reset ? '0 : pend_irdata));
    chk("data_rdata", 64'(data_rdata), 64'(reset ? '0 : pend_drdata));

    pend_i      = gi;
    pend_d      = gd;
    pend_irdata = gi ? ref_rd(inst_addr) : '0;
    pend_drdata = (gd && !data_wr) ? ref_rd(data_addr) : '0;
    if (gd && data_wr) begin
      word = ref_rd(data_addr);
      for (int b = 0; b < SW; b++)
        if (data_wstrb[b]) word[8*b +: 8] = data_wdata[8*b +: 8];
      ref_mem[data_addr] = word;
    end

    if (reset || !inst_req || gi) m_waits = 0;
    else if (gd && m_waits < MAXB) m_waits = m_waits + 1;
  endtask

  // One clock: check at the falling edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    model_cycle();
    s_iaok = inst_addr_ok;  s_daok = data_addr_ok;
    s_idok = inst_data_ok;  s_ddok = data_data_ok;
    s_irdata = inst_rdata;  s_drdata = data_rdata;
    s_en = sram_en; s_addr = sram_addr; s_wen = sram_wen; s_wdata = sram_wdata;
    @(posedge clk);
    #1;
  endtask

  function automatic string grant_char();
    return s_iaok ? "I" : (s_daok ? "D" : "-");
  endfunction

  task automatic set_data(input logic req, input logic wr, input logic [AW-1:0] a,
                          input logic [SW-1:0] st, input logic [DW-1:0] wd);
    data_req = req; data_wr = wr; data_addr = a; data_wstrb = st; data_wdata = wd;
  endtask

  initial begin
    string pat;
    reset = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h200;
    set_data(1'b1, 1'b0, 32'h300, '0, '0);

    // Reset held with both requesting
    tick();
    chk("rst_inst_addr_ok", 64'(s_iaok), 64'd0);
    chk("rst_data_addr_ok", 64'(s_daok), 64'd0);
    tick();
    chk("rst_sram_en", 64'(s_en), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_data_first", 64'(s_daok), 64'd1);
    inst_req = 1'b0;
    set_data(1'b0, 1'b0, '0, '0, '0);
    tick();

    // Preload through the data port
    set_data(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
    tick();
    set_data(1'b1, 1'b1, 32'h40, 4'hF, 32'hAAAAAAAA);
    tick();
    set_data(1'b0, 1'b0, '0, '0, '0);
    tick();

    // Single fetch
    inst_req = 1'b1; inst_addr = 32'h100;
    tick();
    chk("fetch_addr_ok", 64'(s_iaok), 64'd1);
    chk("fetch_sram_addr", 64'(s_addr), 64'h100);
    inst_req = 1'b0;
    tick();
    chk("fetch_data_ok", 64'(s_idok), 64'd1);
    chk("fetch_rdata", 64'(s_irdata), 64'hDEADBEEF);

    // Partial store then load of the same word, back to back
    set_data(1'b1, 1'b1, 32'h40, 4'b0011, 32'h12345678);
    tick();
    chk("store_wen", 64'(s_wen), 64'h3);
    chk("store_wdata", 64'(s_wdata), 64'h12345678);
    set_data(1'b1, 1'b0, 32'h40, '0, '0);
    tick();
    chk("store_ack", 64'(s_ddok), 64'd1);
    chk("store_ack_rdata", 64'(s_drdata), 64'd0);
    chk("load_granted", 64'(s_daok), 64'd1);
    set_data(1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("load_data_ok", 64'(s_ddok), 64'd1);
    chk("load_rdata", 64'(s_drdata), 64'hAAAA5678);

    // Starvation guard under sustained contention
    inst_req = 1'b1; inst_addr = 32'h100;
    set_data(1'b1, 1'b0, 32'h40, '0, '0);
    pat = "";
    for (int i = 0; i < 12; i++) begin
      tick();
      pat = {pat, grant_char()};
    end
    chk_str("starve_pattern", pat, "DDDDIDDDDIDD");
    inst_req = 1'b0;
    set_data(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();

    // Reset arriving the cycle after a load grant
    set_data(1'b1, 1'b0, 32'h100, '0, '0);
    tick();
    chk("midrst_grant", 64'(s_daok), 64'd1);
    set_data(1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    tick();
    chk("midrst_no_data_ok", 64'(s_ddok), 64'd0);
    reset = 1'b0;
    tick();
    chk("midrst_after_ok", 64'(s_ddok), 64'd0);
    chk("midrst_after_rdata", 64'(s_drdata), 64'd0);

    // Fetch request dropping clears the burst count
    inst_req = 1'b1; inst_addr = 32'h40;
    set_data(1'b1, 1'b0, 32'h100, '0, '0);
    pat = "";
    for (int i = 0; i < 3; i++) begin
      tick();
      pat = {pat, grant_char()};
    end
    inst_req = 1'b0;
    tick();
    pat = {pat, grant_char()};
    inst_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      pat = {pat, grant_char()};
    end
    chk_str("withdraw_pattern", pat, "DDDDDDDDI");
    inst_req = 1'b0;
    set_data(1'b0, 1'b0, '0, '0, '0);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
